seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: Clk  input  1  rising-edge clock for all state.
REQ-003 Port: Rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: Start  input  1  request to issue one operation this cycle.
REQ-005 Port: A  input  WIDTH  first operand, sampled on the accept edge.
REQ-006 Port: B  input  WIDTH  second operand, sampled on the accept edge.
REQ-007 Port: Opcode  input  4  operation select, sampled on the accept edge.
REQ-008 Port: Busy  output  1  high while a multi-cycle operation is in progress.
REQ-009 Port: Done  output  1  one-cycle pulse when Result and flags become valid.
REQ-010 Port: Result  output  WIDTH  registered result; holds its value until the next Done.
REQ-011 Port: Zero, Carry, Negative, Overflow  output  1 each  registered flags; update only with Result.

Function
REQ-012 Accept SHALL occur on a rising edge with Start=1 and Busy=0; Start while Busy=1 SHALL be ignored (no queueing).
REQ-013 Opcodes: 0000 add A+B; 0001 shl B<<1; 0010 sub A-B (A+~B+1); 0011 shr B>>1 logical; 0100 mul A*B unsigned; 0101 AND; 0110 OR; 0111 XOR; 1000-1111 undefined.
REQ-014 Single-cycle ops (all except 0100) SHALL register Result/flags on the accept edge, with Done=1 in the following cycle only; Busy stays 0.
REQ-015 Undefined opcodes SHALL follow REQ-014 timing with Result=0, Zero=1 and all other flags 0.
REQ-016 Mul SHALL use an iterative shift-add FSM (IDLE, MUL) with one partial-product step per cycle and a 2*WIDTH-bit accumulator.
REQ-017 Mul timing: accept edge loads operands, sets Busy=1 and counter=WIDTH; Busy falls and Done rises on the WIDTH-th edge after accept; total latency WIDTH cycles.
REQ-018 Mul Result SHALL be product[WIDTH-1:0]; Carry=1 iff product[2*WIDTH-1:WIDTH] is nonzero; Overflow=0.
REQ-019 Add Carry = unsigned carry-out; sub Carry = carry-out of A+~B+1 (1 iff A>=B unsigned).
REQ-020 Add/sub Overflow = signed two's-complement overflow; for all other ops Overflow=0.
REQ-021 shl Carry = B[WIDTH-1]; shr Carry = B[0]; AND/OR/XOR Carry=0.
REQ-022 For all defined ops, Zero = (Result==0) and Negative = Result[WIDTH-1].
REQ-023 Start in the same cycle as Done (Busy=0) SHALL be accepted; back-to-back single-cycle ops SHALL sustain one result per cycle.
REQ-024 Between Done pulses, Result and flags SHALL hold; operand/opcode changes after accept SHALL NOT affect the in-flight operation.

Reset
REQ-025 Rst_n=0 SHALL immediately force FSM=IDLE, Busy=0, Done=0, Result=0, and all flags to 0, including mid-multiply; the aborted operation SHALL produce no Done.
REQ-026 The first rising edge with Rst_n=1 and Start=1 SHALL be a valid accept.

Verification (WIDTH=8)
REQ-027 add A=0x7F,B=0x01 -> next cycle Done=1, Result=0x80, N=1, V=1, C=0, Z=0.
REQ-028 sub A=0x05,B=0x05 -> Result=0x00, Z=1, C=1, V=0; then shr B=0x81 back-to-back -> Result=0x40, C=1.
REQ-029 mul A=0x0F,B=0x11 -> Busy=1 for 8 cycles, Done on 8th edge, Result=0xFF, C=0; mul 0x10*0x10 -> Result=0x00, Z=1, C=1.
REQ-030 Start with add during mul Busy -> ignored; mul Result is unaffected, and no extra Done occurs.
REQ-031 Rst_n pulsed low at cycle 3 of a mul -> all outputs 0 at once, no Done; a following add 0x02+0x03 -> Result=0x05.
REQ-032 Opcode 1010 -> Done next cycle, Result=0x00, Z=1, C=N=V=0.

Source files
------------

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with single-cycle logic/arith ops and an iterative
// shift-add multiplier.
//
// Parameters
//   WIDTH     operand/result width in bits (2..32)
//
// Ports
//   Clk       rising-edge clock
//   Rst_n     asynchronous active-low reset
//   Start     issue request; accepted on a rising edge while Busy=0
//   A, B      operands, sampled on the accept edge
//   Opcode    operation select, sampled on the accept edge
//   Busy      high while a multiply is in progress
//   Done      one-cycle pulse when Result and flags become valid
//   Result    registered result, held until the next Done
//   Zero, Carry, Negative, Overflow
//             registered flags, updated together with Result
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Opcode,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Negative,
    output logic             Overflow
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SHL = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SHR = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;

    typedef enum logic {
        IDLE,
        MUL
    } state_e;

    state_e state_q, state_d;

    logic [2*WIDTH-1:0] acc_q;     // running product
    logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left each step
    logic [WIDTH-1:0]   mplier_q;  // multiplier, shifted right each step
    logic [CW-1:0]      cnt_q;     // steps remaining

    logic [2*WIDTH-1:0] acc_step;
    logic               mul_last;
    logic               accept;

    // Single-cycle datapath
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_ovf;

    assign accept = Start && (state_q == IDLE);
    assign Busy   = (state_q == MUL);

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sum       = '0;
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        case (Opcode)
            OP_ADD: begin
                sum       = {1'b0, A} + {1'b0, B};
                sc_result = sum[WIDTH-1:0];
                sc_carry  = sum[WIDTH];
                sc_ovf    = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                // Carry-out of A + ~B + 1 is the "no borrow" flag (A >= B).
                sum       = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
                sc_result = sum[WIDTH-1:0];
                sc_carry  = sum[WIDTH];
                sc_ovf    = (A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SHL: begin
                sc_result = B << 1;
                sc_carry  = B[MSB];
            end
            OP_SHR: begin
                sc_result = B >> 1;
                sc_carry  = B[0];
            end
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_XOR:  sc_result = A ^ B;
            default: sc_result = '0;   // undefined opcodes: zero result, Z=1 only
        endcase
    end

    // One partial-product step: add the shifted multiplicand when the
    // current multiplier LSB is set.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        mul_last = 1'b0;
        case (state_q)
            IDLE: if (Start && (Opcode == OP_MUL)) state_d = MUL;
            MUL: begin
                if (cnt_q == CW'(1)) begin
                    state_d  = IDLE;
                    mul_last = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Done     <= 1'b0;
            Result   <= '0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Negative <= 1'b0;
            Overflow <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                if (Opcode == OP_MUL) begin
                    acc_q    <= '0;
                    mcand_q  <= {{WIDTH{1'b0}}, A};
                    mplier_q <= B;
                    cnt_q    <= CW'(WIDTH);
                end else begin
                    Done     <= 1'b1;
                    Result   <= sc_result;
                    Zero     <= (sc_result == '0);
                    Carry    <= sc_carry;
                    Negative <= sc_result[MSB];
                    Overflow <= sc_ovf;
                end
            end else if (state_q == MUL) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
                if (mul_last) begin
                    Done     <= 1'b1;
                    Result   <= acc_step[WIDTH-1:0];
                    Zero     <= (acc_step[WIDTH-1:0] == '0);
                    Carry    <= |acc_step[2*WIDTH-1:WIDTH];
                    Negative <= acc_step[MSB];
                    Overflow <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- directed, table-driven bench for seq_alu at WIDTH=8.
// Single-cycle ops run back-to-back from a vector table; multiply, ignored
// Start, Start-on-Done and mid-multiply reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 8;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SHL = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SHR = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   opcode;
    logic         busy, done;
    logic [W-1:0] result;
    logic         zero, carry, negative, overflow;
    logic [3:0]   flags;

    assign flags = {zero, carry, negative, overflow};

    seq_alu #(.WIDTH(W)) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .Start    (start),
        .A        (a),
        .B        (b),
        .Opcode   (opcode),
        .Busy     (busy),
        .Done     (done),
        .Result   (result),
        .Zero     (zero),
        .Carry    (carry),
        .Negative (negative),
        .Overflow (overflow)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive a request just after an edge; it is accepted on the next edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        start  = 1'b1;
        opcode = op;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Multiply and wait for Done; returns while Done is still high.
    // With disturb set, operands change after accept and an add is requested
    // while Busy, neither of which may affect the product.
    task automatic run_mul(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp_res, input logic [3:0] exp_flags,
                           input bit disturb);
        int n;
        bit dropped;
        n       = 0;
        dropped = 0;
        issue(OP_MUL, x, y);
        check({name, "_busy_after_accept"}, {busy, done}, 2'b10);
        do begin
            if (disturb) begin
                a      = 8'h55;
                b      = 8'h66;
                opcode = OP_ADD;
                start  = (n >= 1 && n <= 3);
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && !busy) dropped = 1;
        end while (!done && n < 20);
        start = 1'b0;
        check({name, "_latency"}, n, 8);
        check({name, "_busy_held"}, dropped, 0);
        check({name, "_busy_low_at_done"}, busy, 0);
        check({name, "_result"}, result, exp_res);
        check({name, "_flags"}, flags, exp_flags);
    endtask

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   zcnv;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int ndone;

        vecs[0]  = '{"add_7f_01",   OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b0011};
        vecs[1]  = '{"sub_05_05",   OP_SUB,  8'h05, 8'h05, 8'h00, 4'b1100};
        vecs[2]  = '{"shr_81",      OP_SHR,  8'h00, 8'h81, 8'h40, 4'b0100};
        vecs[3]  = '{"add_ff_01",   OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b1100};
        vecs[4]  = '{"add_80_80",   OP_ADD,  8'h80, 8'h80, 8'h00, 4'b1101};
        vecs[5]  = '{"sub_03_05",   OP_SUB,  8'h03, 8'h05, 8'hFE, 4'b0010};
        vecs[6]  = '{"sub_80_01",   OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b0101};
        vecs[7]  = '{"shl_c3",      OP_SHL,  8'h00, 8'hC3, 8'h86, 4'b0110};
        vecs[8]  = '{"shl_40",      OP_SHL,  8'h00, 8'h40, 8'h80, 4'b0010};
        vecs[9]  = '{"shr_01",      OP_SHR,  8'h00, 8'h01, 8'h00, 4'b1100};
        vecs[10] = '{"and_f0_3c",   OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[11] = '{"or_80_01",    OP_OR,   8'h80, 8'h01, 8'h81, 4'b0010};
        vecs[12] = '{"xor_aa_aa",   OP_XOR,  8'hAA, 8'hAA, 8'h00, 4'b1000};
        vecs[13] = '{"undef_1010",  4'b1010, 8'hFF, 8'hFF, 8'h00, 4'b1000};
        vecs[14] = '{"undef_1111",  4'b1111, 8'h12, 8'h34, 8'h00, 4'b1000};

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        opcode = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {busy, done, result, flags}, 14'h0);

        // First edge after reset release with Start=1 is a valid accept.
        start  = 1'b1;
        opcode = OP_ADD;
        a      = 8'h7F;
        b      = 8'h01;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        check("first_accept_done", done, 1);
        check("first_accept_result", result, 8'h80);
        check("first_accept_flags", flags, 4'b0011);
        @(posedge clk);
        #1;
        check("done_single_pulse", done, 0);
        check("result_hold", result, 8'h80);

        // Back-to-back single-cycle ops: one Done and one result every cycle.
        for (int i = 0; i < 15; i++) begin
            start  = 1'b1;
            opcode = vecs[i].op;
            a      = vecs[i].a;
            b      = vecs[i].b;
            @(posedge clk);
            #1;
            check({vecs[i].name, "_done"},  {busy, done}, 2'b01);
            check({vecs[i].name, "_res"},   result, vecs[i].res);
            check({vecs[i].name, "_flags"}, flags, vecs[i].zcnv);
        end
        start = 1'b0;
        a     = 8'hC3;
        b     = 8'h3C;
        @(posedge clk);
        #1;
        check("table_done_low", done, 0);
        check("table_hold", {result, flags}, {8'h00, 4'b1000});

        // Multiplies.
        run_mul("mul_0f_11", 8'h0F, 8'h11, 8'hFF, 4'b0010, 1'b0);
        @(posedge clk);
        #1;
        run_mul("mul_10_10", 8'h10, 8'h10, 8'h00, 4'b1100, 1'b0);
        @(posedge clk);
        #1;
        run_mul("mul_ff_ff", 8'hFF, 8'hFF, 8'h01, 4'b0100, 1'b0);
        @(posedge clk);
        #1;

        // Start while Busy is ignored; operand changes do not disturb the product.
        run_mul("mul_ignore", 8'h0F, 8'h11, 8'hFF, 4'b0010, 1'b1);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("mul_ignore_no_extra_done", ndone, 0);
        check("mul_ignore_hold", result, 8'hFF);

        // Start during the Done cycle of a multiply is accepted.
        run_mul("mul_02_03", 8'h02, 8'h03, 8'h06, 4'b0000, 1'b0);
        issue(OP_ADD, 8'h10, 8'h20);
        check("start_on_done_done", done, 1);
        check("start_on_done_result", result, 8'h30);

        // Reset in the middle of a multiply.
        @(posedge clk);
        #1;
        issue(OP_ADD, 8'h7F, 8'h01);
        check("pre_reset_result", {result, flags}, {8'h80, 4'b0011});
        issue(OP_MUL, 8'h0F, 8'h11);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("mid_mul_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_mul_reset_outputs", {busy, done, result, flags}, 14'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("aborted_mul_no_done", ndone, 0);
        issue(OP_ADD, 8'h02, 8'h03);
        check("post_reset_add_done", done, 1);
        check("post_reset_add_result", result, 8'h05);
        check("post_reset_add_flags", flags, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
